div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer_if.sv | 34 +++
 rtl/div_sequencer.sv | 167 ++++++++++++++++
 tb/tb_div_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : div_sequencer_if
// Purpose  : Groups the request/response signals of div_sequencer into one
//            bundle.
// Ports    : start/isUnsigned/dividend/divisor/cancel  (request, master->slave)
//            busy/done/quotient/remainder/divByZero    (response, slave->master)
// Revision : 1.0  initial release
// ============================================================================
interface div_sequencer_if #(
    parameter int BitWidth = 32
);
    logic                start;
    logic                isUnsigned;
    logic [BitWidth-1:0] dividend;
    logic [BitWidth-1:0] divisor;
    logic                cancel;
    logic                busy;
    logic                done;
    logic [BitWidth-1:0] quotient;
    logic [BitWidth-1:0] remainder;
    logic                divByZero;

    modport master (
        output start, isUnsigned, dividend, divisor, cancel,
        input  busy, done, quotient, remainder, divByZero
    );

    modport slave (
        input  start, isUnsigned, dividend, divisor, cancel,
        output busy, done, quotient, remainder, divByZero
    );
endinterface
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : div_sequencer
// Purpose  : Multi-cycle radix-2 restoring divider, signed or unsigned,
//            one quotient bit per cycle, cancellable.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - div_sequencer_if.slave (request in, result out)
// Revision : 1.0  initial release
// ============================================================================
module div_sequencer #(
    parameter int BitWidth = 32
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    div_sequencer_if.slave  bus
);

    localparam int c_cnt_w = (BitWidth > 1) ? $clog2(BitWidth) : 1;
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(BitWidth - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic                is_unsigned_q, is_unsigned_d;
    // dvd holds the latched dividend, then its magnitude, and doubles as the
    // shift register into which quotient bits enter from the LSB.
    logic [BitWidth-1:0] dvd_q, dvd_d;
    // dvs holds the latched divisor, then its magnitude.
    logic [BitWidth-1:0] dvs_q, dvs_d;
    logic [BitWidth-1:0] rem_q, rem_d;
    logic                q_neg_q, q_neg_d;
    logic                r_neg_q, r_neg_d;
    logic [BitWidth-1:0] quotient_q, quotient_d;
    logic [BitWidth-1:0] remainder_q, remainder_d;
    logic                div_by_zero_q, div_by_zero_d;
    logic                done_q, done_d;

    logic                w_dvd_neg;
    logic                w_dvs_neg;
    logic [BitWidth:0]   w_shifted;
    logic [BitWidth:0]   w_diff;
    logic                w_qbit;

    // Operand signs only matter in signed mode.
    assign w_dvd_neg = !is_unsigned_q && dvd_q[BitWidth-1];
    assign w_dvs_neg = !is_unsigned_q && dvs_q[BitWidth-1];

    // One restoring step: bring in the next dividend bit and trial-subtract
    // at BitWidth+1 bits so the borrow lands in the top bit.
    assign w_shifted = {rem_q, dvd_q[BitWidth-1]};
    assign w_diff    = w_shifted - {1'b0, dvs_q};
    assign w_qbit    = ~w_diff[BitWidth];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        is_unsigned_d = is_unsigned_q;
        dvd_d         = dvd_q;
        dvs_d         = dvs_q;
        rem_d         = rem_q;
        q_neg_d       = q_neg_q;
        r_neg_d       = r_neg_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // cancel takes priority over start, even when idle
                if (bus.start && !bus.cancel) begin
                    is_unsigned_d = bus.isUnsigned;
                    dvd_d         = bus.dividend;
                    dvs_d         = bus.divisor;
                    state_d       = S_PREP;
                end
            end
            S_PREP: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    dvd_d   = w_dvd_neg ? -dvd_q : dvd_q;
                    dvs_d   = w_dvs_neg ? -dvs_q : dvs_q;
                    rem_d   = '0;
                    q_neg_d = w_dvd_neg ^ w_dvs_neg;
                    r_neg_d = w_dvd_neg;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (bus.cancel) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    rem_d = w_qbit ? w_diff[BitWidth-1:0] : w_shifted[BitWidth-1:0];
                    dvd_d = (dvd_q << 1) | BitWidth'(w_qbit);
                    if (cnt_q == c_last_iter) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.cancel) begin
                    // A zero divisor yields all-ones quotient and the dividend
                    // magnitude as remainder naturally, so no special path.
                    quotient_d    = q_neg_q ? -dvd_q : dvd_q;
                    remainder_d   = r_neg_q ? -rem_q : rem_q;
                    div_by_zero_d = (dvs_q == '0);
                    done_d        = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            is_unsigned_q <= 1'b0;
            dvd_q         <= '0;
            dvs_q         <= '0;
            rem_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_unsigned_q <= is_unsigned_d;
            dvd_q         <= dvd_d;
            dvs_q         <= dvs_d;
            rem_q         <= rem_d;
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            done_q        <= done_d;
        end
    end

    // busy follows the state register so it rises on the accepting edge and
    // falls on the same edge that done rises.
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.divByZero = div_by_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_sequencer
// Purpose  : Scoreboard bench for div_sequencer: directed divisions, cancel,
//            ignored starts, back-to-back start and mid-operation reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_sequencer;

    logic clk;
    logic rst_n;
    int   edges;
    int   n_checks;
    int   n_pass;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t sb[$];

    div_sequencer_if #(.BitWidth(32)) bus ();

    div_sequencer #(.BitWidth(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edges = 0;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient",  bus.quotient, e.q);
                check("remainder", bus.remainder, e.r);
                check("divByZero", {31'd0, bus.divByZero}, {31'd0, e.dbz});
                check("latency",   edges, e.due);
                check("busy_at_done", {31'd0, bus.busy}, 32'd0);
            end
        end
    end

    task automatic issue(input logic uns, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.isUnsigned = uns;
        bus.dividend   = a;
        bus.divisor    = b;
        if (push) sb.push_back('{eq, er, edbz, edges + 35});
        @(negedge clk);
        bus.start      = 1'b0;
        bus.dividend   = $urandom;
        bus.divisor    = $urandom;
        bus.isUnsigned = 1'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", sb.size(), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      {31'd0, bus.busy}, 32'd0);
        check({tag, "_done"},      {31'd0, bus.done}, 32'd0);
        check({tag, "_quotient"},  bus.quotient, 32'd0);
        check({tag, "_remainder"}, bus.remainder, 32'd0);
        check({tag, "_divByZero"}, {31'd0, bus.divByZero}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.cancel     = 1'b0;
        bus.isUnsigned = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Basic unsigned division and busy on the accepting edge
        issue(1'b1, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        drain();

        // Signed, overflow, divide by zero, large unsigned
        issue(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        drain();
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        drain();
        issue(1'b1, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1);
        drain();
        issue(1'b0, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'd1, 32'hFFFF_FFFB, 1'b1);
        drain();
        issue(1'b1, 32'hFFFF_FFFF, 32'd16, 1'b1, 32'h0FFF_FFFF, 32'd15, 1'b0);
        drain();
        issue(1'b1, 32'd9, 32'd2, 1'b1, 32'd4, 32'd1, 1'b0);
        drain();

        // Cancel at edge 10 of 100/7: no done, results held at 4 r 1
        issue(1'b1, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel_busy",      {31'd0, bus.busy}, 32'd0);
        check("cancel_quotient",  bus.quotient, 32'd4);
        check("cancel_remainder", bus.remainder, 32'd1);
        repeat (40) @(negedge clk);
        check("hold_quotient",  bus.quotient, 32'd4);
        check("hold_remainder", bus.remainder, 32'd1);

        // Start together with cancel in IDLE is ignored
        bus.start    = 1'b1;
        bus.cancel   = 1'b1;
        bus.dividend = 32'd8;
        bus.divisor  = 32'd2;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check("start_cancel_busy", {31'd0, bus.busy}, 32'd0);

        // Start pulses at edges 5 and 20 during an operation are ignored
        issue(1'b1, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd1;
        bus.divisor  = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // Back-to-back: start driven while done is high
        issue(1'b1, 32'd50, 32'd3, 1'b1, 32'd16, 32'd2, 1'b0);
        for (int i = 0; i < 60 && bus.done !== 1'b1; i++) @(negedge clk);
        check("b2b_done_seen", {31'd0, bus.done}, 32'd1);
        bus.start      = 1'b1;
        bus.isUnsigned = 1'b1;
        bus.dividend   = 32'd77;
        bus.divisor    = 32'd7;
        sb.push_back('{32'd11, 32'd0, 1'b0, edges + 35});
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        drain();

        // Reset at edge 15 mid-operation, then a normal operation
        issue(1'b1, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b1, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, 1'b0);
        drain();

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
